mem_arbiter: RTL and testbench

Two-port line-fill arbiter between the instruction/data caches and the single external memory port. It takes line-read requests from the icache miss path, and line-read or line-write requests from the dcache miss/writeback path. It grants one request at a time with round-robin fairness, drives the memory command/data handshakes and routes returned beats to the requester. Cache stall generation stays in the caches; this block only serialises their traffic.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_arb2.sv | 38 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the cache line-fill arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DC = 1'b1
   } gnt_t;

   // Clear the line-offset bits so the memory always sees a line-aligned address.
   function automatic logic [31:0] LINE_ALIGN(input logic [31:0] addr, input int unsigned off_w);
      logic [31:0] mask;
      mask = (32'h1 << off_w) - 32'h1;
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. gnt[0] = icache, gnt[1] = dcache.
// On a tie the port that did not win last time is chosen.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req_ic,
   input  logic       req_dc,
   output logic [1:0] gnt
);

   gnt_t last_grant;

   // One-hot grant, only while enabled.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req_ic && req_dc) begin
            if (last_grant == GNT_IC) gnt = 2'b10;
            else                      gnt = 2'b01;
         end else if (req_ic) begin
            gnt = 2'b01;
         end else if (req_dc) begin
            gnt = 2'b10;
         end
      end
   end

   // Remember the winner so the next tie goes the other way.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         last_grant <= GNT_IC;
      else if (gnt[1])  last_grant <= GNT_DC;
      else if (gnt[0])  last_grant <= GNT_IC;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache line traffic onto the single external memory port:
// arbitrates, issues the line command, moves write beats and routes read beats.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BEATS = 4,
   parameter int OFF_W = $clog2(BEATS*4)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ic_req_valid,
   input  logic [31:0] ic_req_addr,
   output logic        ic_req_ready,
   input  logic        dc_req_valid,
   input  logic        dc_req_we,
   input  logic [31:0] dc_req_addr,
   output logic        dc_req_ready,
   input  logic [31:0] dc_wdata,
   input  logic        dc_wdata_valid,
   output logic        dc_wdata_ready,
   output logic        mem_cmd_valid,
   output logic        mem_cmd_we,
   output logic [31:0] mem_cmd_addr,
   input  logic        mem_cmd_ready,
   output logic [31:0] mem_wdata,
   output logic        mem_wdata_valid,
   input  logic        mem_wdata_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_valid,
   output logic [31:0] ic_rdata,
   output logic        ic_rdata_valid,
   output logic [31:0] dc_rdata,
   output logic        dc_rdata_valid,
   output logic        busy,
   output logic        proto_err
);

   localparam int              CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

   state_t           state, state_nxt;
   logic [31:0]      addr_q;
   logic             we_q;
   gnt_t             owner_q;
   logic [CNT_W-1:0] beat_q;
   logic [1:0]       gnt;
   logic             wr_fire, rd_fire, last_beat;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (state == IDLE),
      .req_ic (ic_req_valid),
      .req_dc (dc_req_valid),
      .gnt    (gnt)
   );

   assign wr_fire   = (state == WDATA) && dc_wdata_valid && mem_wdata_ready;
   assign rd_fire   = (state == RDATA) && mem_rdata_valid;
   assign last_beat = (beat_q == LAST_BEAT);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; a line ends on its last beat and always returns to IDLE,
   // so a request coinciding with the last beat waits one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|gnt) state_nxt = CMD;
         CMD:     if (mem_cmd_ready) state_nxt = we_q ? WDATA : RDATA;
         WDATA:   if (wr_fire && last_beat) state_nxt = IDLE;
         RDATA:   if (rd_fire && last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the granted request; icache requests are always reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         owner_q <= GNT_IC;
      end else if (state == IDLE && |gnt) begin
         if (gnt[1]) begin
            addr_q  <= LINE_ALIGN(dc_req_addr, OFF_W);
            we_q    <= dc_req_we;
            owner_q <= GNT_DC;
         end else begin
            addr_q  <= LINE_ALIGN(ic_req_addr, OFF_W);
            we_q    <= 1'b0;
            owner_q <= GNT_IC;
         end
      end
   end

   // Beat counter: cleared when the command is taken, wraps on the last beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_q <= '0;
      end else if (state == CMD && mem_cmd_ready) begin
         beat_q <= '0;
      end else if (wr_fire || rd_fire) begin
         beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
   end

   // Sticky protocol error: read beat with no read line in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    proto_err <= 1'b0;
      else if (mem_rdata_valid && state != RDATA)  proto_err <= 1'b1;
   end

   // Handshake outputs and beat routing.
   always_comb begin
      ic_req_ready    = gnt[0];
      dc_req_ready    = gnt[1];
      busy            = (state != IDLE);
      mem_cmd_valid   = (state == CMD);
      mem_cmd_we      = we_q;
      mem_cmd_addr    = addr_q;
      mem_wdata       = (state == WDATA) ? dc_wdata : 32'h0;
      mem_wdata_valid = (state == WDATA) && dc_wdata_valid;
      dc_wdata_ready  = (state == WDATA) && mem_wdata_ready;
      ic_rdata        = mem_rdata;
      dc_rdata        = mem_rdata;
      ic_rdata_valid  = rd_fire && (owner_q == GNT_IC);
      dc_rdata_valid  = rd_fire && (owner_q == GNT_DC);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench with a scoreboard: stimulus pushes expected grants, commands and
// beats into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

   localparam int BEATS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ic_req_valid = 0, dc_req_valid = 0, dc_req_we = 0;
   logic [31:0] ic_req_addr = 0, dc_req_addr = 0, dc_wdata = 0, mem_rdata = 0;
   logic        dc_wdata_valid = 0, mem_cmd_ready = 0, mem_wdata_ready = 0, mem_rdata_valid = 0;
   logic        ic_req_ready, dc_req_ready, dc_wdata_ready;
   logic        mem_cmd_valid, mem_cmd_we, mem_wdata_valid;
   logic [31:0] mem_cmd_addr, mem_wdata, ic_rdata, dc_rdata;
   logic        ic_rdata_valid, dc_rdata_valid, busy, proto_err;

   int n_chk = 0, n_pass = 0;
   int ic_left = 0, dc_left = 0;
   bit wr_acc;

   logic [32:0] exp_cmd[$];
   logic [31:0] exp_ic[$], exp_dc[$], exp_wd[$];
   bit          exp_gnt[$];

   mem_arbiter #(.BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
      .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_valid(dc_wdata_valid),
      .dc_wdata_ready(dc_wdata_ready), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_ready(mem_cmd_ready), .mem_wdata(mem_wdata),
      .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .ic_rdata(ic_rdata), .ic_rdata_valid(ic_rdata_valid),
      .dc_rdata(dc_rdata), .dc_rdata_valid(dc_rdata_valid),
      .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail_msg(input string nm);
      n_chk++;
      $display("FAIL %s", nm);
   endtask

   // Monitor: every DUT output event must match the head of its queue.
   always @(negedge clk) begin
      if (rst) begin
         if (ic_req_ready && dc_req_ready) fail_msg("dual_grant");
         else if (ic_req_ready || dc_req_ready) begin
            if (exp_gnt.size() == 0) fail_msg("unexpected_grant");
            else chk("grant_is_dc", 33'(dc_req_ready), 33'(exp_gnt.pop_front()));
         end
         if (mem_cmd_valid && mem_cmd_ready) begin
            if (exp_cmd.size() == 0) fail_msg("unexpected_cmd");
            else chk("cmd_we_addr", {mem_cmd_we, mem_cmd_addr}, exp_cmd.pop_front());
         end
         if (ic_rdata_valid && dc_rdata_valid) fail_msg("both_rdata_valid");
         if (ic_rdata_valid) begin
            if (exp_ic.size() == 0) fail_msg("unexpected_ic_rdata");
            else chk("ic_rdata", 33'(ic_rdata), 33'(exp_ic.pop_front()));
         end
         if (dc_rdata_valid) begin
            if (exp_dc.size() == 0) fail_msg("unexpected_dc_rdata");
            else chk("dc_rdata", 33'(dc_rdata), 33'(exp_dc.pop_front()));
         end
         if (mem_wdata_valid) chk("wdata_ready_mirror", 33'(dc_wdata_ready), 33'(mem_wdata_ready));
         if (mem_wdata_valid && mem_wdata_ready) begin
            if (exp_wd.size() == 0) fail_msg("unexpected_wbeat");
            else chk("mem_wdata", 33'(mem_wdata), 33'(exp_wd.pop_front()));
         end
      end
   end

   // One cycle: sample at negedge, then advance to just after the next posedge,
   // dropping a requester's valid once its last wanted grant has been seen.
   task automatic step();
      bit gi, gd;
      @(negedge clk);
      gi = ic_req_ready; gd = dc_req_ready;
      wr_acc = dc_wdata_valid && dc_wdata_ready;
      @(posedge clk); #1;
      if (gi) begin ic_left--; if (ic_left <= 0) ic_req_valid = 0; end
      if (gd) begin dc_left--; if (dc_left <= 0) dc_req_valid = 0; end
   endtask

   task automatic serve_cmd(input logic [31:0] ea, input logic ew, input int stall,
                            output logic we, output bit ok);
      int t = 0;
      ok = 1; we = 0;
      while (!mem_cmd_valid) begin
         if (t == 50) begin fail_msg("cmd_timeout"); ok = 0; return; end
         step(); t++;
      end
      for (int s = 0; s < stall; s++) begin
         step();
         chk("stall_valid", 33'(mem_cmd_valid), 33'd1);
         chk("stall_cmd", {mem_cmd_we, mem_cmd_addr}, {ew, ea});
      end
      mem_cmd_ready = 1; we = mem_cmd_we;
      step();
      mem_cmd_ready = 0;
   endtask

   task automatic serve_rd(input logic [31:0] base, input int n);
      for (int b = 0; b < n; b++) begin
         mem_rdata_valid = 1; mem_rdata = base + 32'(b);
         step();
      end
      mem_rdata_valid = 0; mem_rdata = 0;
   endtask

   task automatic serve_wr(input logic [31:0] base, input bit toggle);
      int wb = 0, c = 0;
      dc_wdata_valid = 1; dc_wdata = base;
      while (wb < BEATS) begin
         if (c == 60) begin fail_msg("wdata_timeout"); break; end
         mem_wdata_ready = toggle ? ((c % 2) == 0) : 1'b1;
         step(); c++;
         if (wr_acc) begin wb++; dc_wdata = base + 32'(wb); end
      end
      mem_wdata_ready = 0; dc_wdata_valid = 0;
   endtask

   task automatic serve(input logic [31:0] ea, input logic ew, input int stall,
                        input bit toggle, input logic [31:0] base);
      logic we; bit ok;
      serve_cmd(ea, ew, stall, we, ok);
      if (!ok) return;
      if (we) serve_wr(base, toggle);
      else    serve_rd(base, BEATS);
      chk("busy_after_line", 33'(busy), 33'd0);
   endtask

   task automatic push_rd(input bit dc, input logic [31:0] base);
      for (int b = 0; b < BEATS; b++) begin
         if (dc) exp_dc.push_back(base + 32'(b));
         else    exp_ic.push_back(base + 32'(b));
      end
   endtask

   initial begin
      logic we; bit ok;
      #3;
      chk("rst_busy",      33'(busy), 33'd0);
      chk("rst_proto_err", 33'(proto_err), 33'd0);
      chk("rst_cmd_valid", 33'(mem_cmd_valid), 33'd0);
      chk("rst_cmd",       {mem_cmd_we, mem_cmd_addr}, 33'd0);
      chk("rst_wvalid",    33'(mem_wdata_valid), 33'd0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;

      // Tie out of reset, then alternation while both stay valid.
      ic_req_addr = 32'h0000_1234; dc_req_addr = 32'h0000_2048; dc_req_we = 0;
      ic_left = 2; dc_left = 2;
      exp_gnt = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_cmd.push_back({1'b0, 32'h2040}); exp_cmd.push_back({1'b0, 32'h1230});
      exp_cmd.push_back({1'b0, 32'h2040}); exp_cmd.push_back({1'b0, 32'h1230});
      push_rd(1, 32'hB0); push_rd(0, 32'hA0); push_rd(1, 32'hC0); push_rd(0, 32'hD0);
      ic_req_valid = 1; dc_req_valid = 1;
      serve(32'h2040, 0, 0, 0, 32'hB0);
      serve(32'h1230, 0, 0, 0, 32'hA0);
      serve(32'h2040, 0, 0, 0, 32'hC0);
      serve(32'h1230, 0, 0, 0, 32'hD0);

      // Single icache read.
      ic_left = 1; exp_gnt.push_back(1'b0);
      exp_cmd.push_back({1'b0, 32'h1230}); push_rd(0, 32'hA0);
      ic_req_valid = 1;
      serve(32'h1230, 0, 0, 0, 32'hA0);

      // Dcache write with mem_wdata_ready toggling.
      dc_left = 1; dc_req_we = 1; dc_req_addr = 32'h40;
      exp_gnt.push_back(1'b1); exp_cmd.push_back({1'b1, 32'h40});
      for (int b = 0; b < BEATS; b++) exp_wd.push_back(32'h5000_0000 + 32'(b));
      dc_req_valid = 1;
      serve(32'h40, 1, 0, 1, 32'h5000_0000);
      dc_req_we = 0;

      // Stray read beat while idle.
      mem_rdata_valid = 1; mem_rdata = 32'h77;
      step();
      mem_rdata_valid = 0; mem_rdata = 0;
      chk("stray_proto_err", 33'(proto_err), 33'd1);
      chk("stray_busy",      33'(busy), 33'd0);

      // Command held off for 5 cycles.
      ic_left = 1; ic_req_addr = 32'h0000_ABCF;
      exp_gnt.push_back(1'b0); exp_cmd.push_back({1'b0, 32'hABC0}); push_rd(0, 32'h60);
      ic_req_valid = 1;
      serve(32'hABC0, 0, 5, 0, 32'h60);
      chk("proto_err_sticky", 33'(proto_err), 33'd1);

      // Reset during read beat 2.
      ic_left = 1; ic_req_addr = 32'h300;
      exp_gnt.push_back(1'b0); exp_cmd.push_back({1'b0, 32'h300});
      exp_ic.push_back(32'hE0); exp_ic.push_back(32'hE1);
      ic_req_valid = 1;
      serve_cmd(32'h300, 0, 0, we, ok);
      if (ok) serve_rd(32'hE0, 2);
      mem_rdata_valid = 1; mem_rdata = 32'hE2;
      #1 rst = 0;
      #1 mem_rdata_valid = 0; mem_rdata = 0;
      #1;
      chk("arst_ic_rvalid",  33'(ic_rdata_valid), 33'd0);
      chk("arst_busy",       33'(busy), 33'd0);
      chk("arst_cmd_valid",  33'(mem_cmd_valid), 33'd0);
      chk("arst_cmd",        {mem_cmd_we, mem_cmd_addr}, 33'd0);
      chk("arst_proto_err",  33'(proto_err), 33'd0);
      chk("arst_ic_rdata",   33'(ic_rdata), 33'd0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;
      chk("post_rst_busy", 33'(busy), 33'd0);

      // Fresh icache read after reset.
      ic_left = 1; ic_req_addr = 32'h0000_0404;
      exp_gnt.push_back(1'b0); exp_cmd.push_back({1'b0, 32'h400}); push_rd(0, 32'hF0);
      ic_req_valid = 1;
      serve(32'h400, 0, 0, 0, 32'hF0);
      step();

      chk("left_gnt", 33'(exp_gnt.size()), 33'd0);
      chk("left_cmd", 33'(exp_cmd.size()), 33'd0);
      chk("left_ic",  33'(exp_ic.size()), 33'd0);
      chk("left_dc",  33'(exp_dc.size()), 33'd0);
      chk("left_wd",  33'(exp_wd.size()), 33'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
